pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/adder_pkg.sv | 12 +
 rtl/pipe_adder_if.sv | 29 ++
 rtl/adder_slice.sv | 28 ++
 rtl/full_adder.sv | 11 +
 rtl/pipe_adder.sv | 121 ++++++++++++
 tb/tb_pipe_adder.sv | 260 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder: default geometry and the add/sub mode encoding.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder; slave is the adder side, master the producer/consumer.
interface pipe_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/adder_slice.sv
// Purely combinational CHUNK-bit ripple adder built from full_adder cells.
module adder_slice
    import adder_pkg::*;
#(
    parameter int CHUNK = DEFAULT_WIDTH / DEFAULT_STAGES
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o
);
    logic [CHUNK:0] carry;

    assign carry[0] = c_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry[i]),
            .s_o (s_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign c_o = carry[CHUNK];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple slices.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: stage k adds chunk k, skew registers carry the rest of each beat along.
// Define PIPE_ADDER_FLAGS_EN to compute the ovf/zero flags; otherwise both outputs are tied to 0.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input logic         clk,
    input logic         reset,
    pipe_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    mode_e            mode;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             advance;

    assign mode    = mode_e'(bus.sub);
    assign b_eff   = (mode == MODE_SUB) ? ~bus.b : bus.b;
    assign cin_eff = (mode == MODE_SUB) ? 1'b1 : bus.cin;

    // A single enable for every stage: a stalled result freezes the whole pipe, so nothing is overwritten.
    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << (k * CHUNK)) - WIDTH'(1);

        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] sum_src;
        logic             c_src;
        logic             v_src;
        logic [CHUNK-1:0] chunk_sum;
        logic             chunk_cout;
        logic [WIDTH-1:0] sum_d;
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;
        logic             valid_q;

        if (k == 0) begin : g_head
            assign a_src   = bus.a;
            assign b_src   = b_eff;
            assign sum_src = '0;
            assign c_src   = cin_eff;
            assign v_src   = bus.in_valid;
        end else begin : g_body
            assign a_src   = g_stage[k-1].g_skew.a_q;
            assign b_src   = g_stage[k-1].g_skew.b_q;
            assign sum_src = g_stage[k-1].sum_q;
            assign c_src   = g_stage[k-1].carry_q;
            assign v_src   = g_stage[k-1].valid_q;
        end

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a_i (CHUNK'(a_src >> (k * CHUNK))),
            .b_i (CHUNK'(b_src >> (k * CHUNK))),
            .c_i (c_src),
            .s_o (chunk_sum),
            .c_o (chunk_cout)
        );

        assign sum_d = (sum_src & LOW_MASK) | (WIDTH'(chunk_sum) << (k * CHUNK));

        // NOTE: non-blocking assignments make every stage sample its neighbour's pre-edge value.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= v_src;
                carry_q <= v_src & chunk_cout;
                sum_q   <= v_src ? sum_d : '0;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_src;
                    b_q <= b_src;
                end
            end
        end else begin : g_tail
            assign bus.out_valid = valid_q;
            assign bus.sum       = sum_q;
            assign bus.cout      = carry_q;
`ifdef PIPE_ADDER_FLAGS_EN
            logic ovf_q;
            logic zero_q;

            // Bubbles load zeros so idle outputs read as all-zero, matching the post-reset state.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    ovf_q  <= v_src & (a_src[WIDTH-1] == b_src[WIDTH-1])
                                    & (sum_d[WIDTH-1] != a_src[WIDTH-1]);
                    zero_q <= v_src & (sum_d == '0);
                end
            end

            assign bus.ovf  = ovf_q;
            assign bus.zero = zero_q;
`else
            assign bus.ovf  = 1'b0;
            assign bus.zero = 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, STAGES=4): directed vectors, backpressure,
// mid-flight reset and randomized traffic scored against an arithmetic reference model.
module tb_pipe_adder;
    import adder_pkg::*;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
`ifdef PIPE_ADDER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef logic [WIDTH-1:0] word_t;
    typedef struct packed {
        word_t sum;
        logic  cout;
        logic  ovf;
        logic  zero;
    } res_t;
    typedef struct packed {
        word_t a;
        word_t b;
        logic  sub;
        logic  cin;
        res_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   errors   = 0;
    int   received = 0;
    res_t sb_q[$];

    pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_res(input string name, input res_t act, input res_t exp);
        check({name, ".sum"},  32'(act.sum),  32'(exp.sum));
        check({name, ".cout"}, 32'(act.cout), 32'(exp.cout));
        check({name, ".ovf"},  32'(act.ovf),  32'(exp.ovf));
        check({name, ".zero"}, 32'(act.zero), 32'(exp.zero));
    endtask

    function automatic res_t dut_res();
        res_t r;
        r.sum  = bus.sum;
        r.cout = bus.cout;
        r.ovf  = bus.ovf;
        r.zero = bus.zero;
        return r;
    endfunction

    // Reference: unsigned result/carry and signed range test in wide integers.
    function automatic res_t model(input word_t a, input word_t b, input bit s, input bit c);
        res_t   r;
        longint ua, ub, ur, sa, sb, sr;
        longint smax, smin;
        smax = (longint'(1) << (WIDTH - 1)) - 1;
        smin = -(longint'(1) << (WIDTH - 1));
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            ur     = ua - ub;
            sr     = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            ur     = ua + ub + longint'(c);
            sr     = sa + sb + longint'(c);
            r.cout = (ur >= (longint'(1) << WIDTH));
        end
        r.sum  = word_t'(ur);
        r.ovf  = FLAGS && (sr > smax || sr < smin);
        r.zero = FLAGS && (r.sum == '0);
        return r;
    endfunction

    function automatic vec_t mk_vec(input word_t a, input word_t b, input bit s, input bit c,
                                    input word_t sum, input bit co, input bit ov, input bit z);
        vec_t v;
        v.a        = a;
        v.b        = b;
        v.sub      = s;
        v.cin      = c;
        v.exp.sum  = sum;
        v.exp.cout = co;
        v.exp.ovf  = ov & FLAGS;
        v.exp.zero = z & FLAGS;
        return v;
    endfunction

    task automatic drive(input bit v, input word_t a, input word_t b, input bit s, input bit c,
                         input bit rdy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.sub       = s;
        bus.cin       = c;
        bus.out_ready = rdy;
    endtask

    // One handshake cycle: drive after the falling edge, score what the DUT shows, then take the edge.
    task automatic stream_cycle(input bit v, input word_t a, input word_t b, input bit s,
                                input bit c, input bit rdy, output bit accepted);
        @(negedge clk);
        drive(v, a, b, s, c, rdy);
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !rdy)));
        if (bus.out_valid && rdy) begin
            if (sb_q.size() == 0) begin
                check("spurious_out_valid", 32'(bus.out_valid), 32'(0));
            end else begin
                check_res("stream", dut_res(), sb_q.pop_front());
                received++;
            end
        end
        accepted = v && bus.in_ready;
        if (accepted) sb_q.push_back(model(a, b, s, c));
        @(posedge clk);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int n;
        bit seen;
        @(negedge clk);
        drive(1'b1, v.a, v.b, v.sub, v.cin, 1'b1);
        #1;
        check({name, ".in_ready"}, 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = bus.out_valid;
        end
        check({name, ".latency"}, 32'(n), 32'(STAGES));
        check_res(name, dut_res(), v.exp);
        @(posedge clk);
    endtask

    function automatic word_t pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return word_t'(1) << (WIDTH - 1);
            3:       return (word_t'(1) << (WIDTH - 1)) - word_t'(1);
            default: return word_t'($urandom);
        endcase
    endfunction

    initial begin
        vec_t vecs[10];
        bit   pat[4];
        bit   acc;
        int   sent;
        int   cyc;

        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.in_ready", 32'(bus.in_ready), 32'(1));
        check("rst.out_valid", 32'(bus.out_valid), 32'(0));
        check_res("rst", dut_res(), res_t'(0));

        vecs[0] = mk_vec(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk_vec(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        vecs[2] = mk_vec(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        vecs[3] = mk_vec(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        vecs[4] = mk_vec(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        vecs[5] = mk_vec(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        vecs[6] = mk_vec(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        vecs[7] = mk_vec(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        vecs[8] = mk_vec(16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        vecs[9] = mk_vec(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Ten back-to-back beats under a 1,0,0,1 out_ready pattern.
        pat      = '{1'b1, 1'b0, 1'b0, 1'b1};
        sent     = 0;
        received = 0;
        cyc      = 0;
        while ((sent < 10 || received < 10) && cyc < 200) begin
            stream_cycle(sent < 10, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom),
                         pat[cyc % 4], acc);
            if (acc) sent++;
            cyc++;
        end
        check("bp.sent", 32'(sent), 32'(10));
        check("bp.received", 32'(received), 32'(10));
        for (int i = 0; i < 6; i++) stream_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        check("bp.queue_empty", 32'(sb_q.size()), 32'(0));

        // Three beats in flight, then a one-cycle reset must discard them.
        for (int i = 0; i < 3; i++)
            stream_cycle(1'b1, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), 1'b1, acc);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) check("mid_rst.in_ready", 32'(bus.in_ready), 32'(1));
            check("mid_rst.out_valid", 32'(bus.out_valid), 32'(0));
            check_res("mid_rst", dut_res(), res_t'(0));
        end

        // Random traffic with random bubbles and backpressure, then drain.
        sent     = 0;
        received = 0;
        for (int i = 0; i < 400; i++) begin
            stream_cycle($urandom_range(0, 3) != 0, pick_operand(), pick_operand(), 1'($urandom),
                         1'($urandom), 1'($urandom), acc);
            if (acc) sent++;
        end
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 50) begin
            stream_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            cyc++;
        end
        check("rand.received", 32'(received), 32'(sent));
        check("rand.queue_empty", 32'(sb_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
